// File: rtl/sig_bwd_pkg.sv
// Shared Q8.8 constants, types and accumulator defaults for the sigmoid backward path.
// SIG_BWD_ROUND_EN selects round-half-up on delta instead of floor.
package sig_bwd_pkg;

  localparam int Q_FRAC = 8;
  localparam int Q_ONE  = 256;
  localparam int Q_HALF = 128;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 16;

  typedef logic signed [15:0] q88_t;
  typedef logic        [15:0] uq88_t;

  localparam int ACC_MAX_DEF = (1 << (ACC_W_DEF - 1)) - 1;
  localparam int ACC_MIN_DEF = -(1 << (ACC_W_DEF - 1));

`ifdef SIG_BWD_ROUND_EN
  localparam int ROUND_BIAS = Q_HALF;
`else
  localparam int ROUND_BIAS = 0;
`endif

endpackage

// File: rtl/sig_deriv_calc.sv
// Combinational sigmoid derivative: clamp s to 1.0, then d = s*(1-s) in Q8.8 (truncated).
module sig_deriv_calc
  import sig_bwd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] sig,
  output logic [DATA_W-1:0] deriv
);

  logic [8:0]  sc;
  logic [8:0]  one_minus;
  logic [17:0] prod;

  always_comb begin
    sc = (sig > DATA_W'(Q_ONE)) ? 9'(Q_ONE) : sig[8:0];
    one_minus = 9'(Q_ONE) - sc;
    prod = {9'd0, sc} * {9'd0, one_minus};
    deriv = DATA_W'(prod >> Q_FRAC);
  end

endmodule

// File: rtl/sig_bwd_delta.sv
// Two-stage valid/ready pipeline computing delta = e * s(1-s) with a saturating accumulator.
// Rounding of delta is controlled by SIG_BWD_ROUND_EN (see sig_bwd_pkg).
module sig_bwd_delta
  import sig_bwd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_sig,
  input  logic [DATA_W-1:0]        in_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_delta,
  output logic [DATA_W-1:0]        out_deriv,
  input  logic                     acc_clr,
  output logic signed [ACC_W-1:0]  acc_sum,
  output logic [CNT_W-1:0]         sample_cnt
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                     s1_valid;
  logic                     s1_adv;
  logic                     in_fire;
  logic                     out_fire;
  logic [DATA_W-1:0]        s1_deriv;
  logic signed [DATA_W-1:0] s1_err;
  logic [DATA_W-1:0]        calc_deriv;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     prod_biased;
  logic signed [PW-1:0]     delta_full;
  logic signed [ACC_W:0]    acc_base;
  logic signed [ACC_W:0]    acc_next;
  logic signed [ACC_W-1:0]  acc_sat;

  sig_deriv_calc #(.DATA_W(DATA_W)) u_deriv (
    .sig   (in_sig),
    .deriv (calc_deriv)
  );

  // Ready depends only on registered state, never on in_valid.
  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    prod        = PW'(s1_err) * $signed({{DATA_W{1'b0}}, s1_deriv});
    prod_biased = prod + PW'(ROUND_BIAS);
    delta_full  = prod_biased >>> Q_FRAC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_deriv  <= '0;
      s1_err    <= '0;
      out_valid <= 1'b0;
      out_delta <= '0;
      out_deriv <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_deriv <= calc_deriv;
        s1_err   <= $signed(in_err);
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_delta <= DATA_W'(delta_full);
          out_deriv <= s1_deriv;
        end
      end
    end
  end

  // Clear takes effect before the add, so a clear during a fire leaves just that delta.
  always_comb begin
    acc_base = acc_clr ? '0 : {acc_sum[ACC_W-1], acc_sum};
    acc_next = acc_base + (ACC_W+1)'(out_delta);
    if (acc_next[ACC_W] != acc_next[ACC_W-1])
      acc_sat = acc_next[ACC_W] ? ACC_MIN : ACC_MAX;
    else
      acc_sat = acc_next[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum    <= '0;
      sample_cnt <= '0;
    end else begin
      if (out_fire) begin
        acc_sum    <= acc_sat;
        sample_cnt <= acc_clr ? CNT_W'(1) : sample_cnt + CNT_W'(1);
      end else if (acc_clr) begin
        acc_sum    <= '0;
        sample_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sig_bwd_delta.sv
// Self-checking bench for sig_bwd_delta: directed table, backpressure, saturation, reset and random traffic.
module tb_sig_bwd_delta;

`ifdef SIG_BWD_ROUND_EN
  localparam int RND_BIAS = 128;
  localparam int RND_154  = 1;
`else
  localparam int RND_BIAS = 0;
  localparam int RND_154  = 0;
`endif
  localparam int ACC_MAX = 8388607;
  localparam int ACC_MIN = -8388608;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        in_sig;
  logic [15:0]        in_err;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_delta;
  logic [15:0]        out_deriv;
  logic               acc_clr;
  logic signed [23:0] acc_sum;
  logic [15:0]        sample_cnt;

  sig_bwd_delta dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sig     (in_sig),
    .in_err     (in_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_delta  (out_delta),
    .out_deriv  (out_deriv),
    .acc_clr    (acc_clr),
    .acc_sum    (acc_sum),
    .sample_cnt (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int exp_d_q[$];
  int exp_delta_q[$];
  int m_acc = 0;
  int m_cnt = 0;
  int n_out = 0;
  int last_d, last_delta;
  bit got_out;
  bit stalled = 0;
  int hold_delta, hold_deriv;

  typedef struct {
    int s;
    int e;
    int d;
    int delta;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_deriv(input int s);
    int sc;
    sc = (s > 256) ? 256 : s;
    return (sc * (256 - sc)) / 256;
  endfunction

  function automatic int ref_delta(input int s, input int e);
    int p, q;
    p = e * ref_deriv(s) + RND_BIAS;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int sat(input int v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < ACC_MIN) return ACC_MIN;
    return v;
  endfunction

  // One clock: observe handshakes at negedge, update the model, then check accumulator after the edge.
  task automatic cycle(output bit fired);
    int ed, edl;
    @(negedge clk);
    fired = in_valid && in_ready;
    if (fired) begin
      exp_d_q.push_back(ref_deriv(int'(in_sig)));
      exp_delta_q.push_back(ref_delta(int'(in_sig), int'($signed(in_err))));
    end
    if (stalled) begin
      chk("stall_delta_stable", int'(out_delta), hold_delta);
      chk("stall_deriv_stable", int'(out_deriv), hold_deriv);
    end
    if (acc_clr) begin
      m_acc = 0;
      m_cnt = 0;
    end
    if (out_valid && out_ready) begin
      if (exp_d_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        ed  = exp_d_q.pop_front();
        edl = exp_delta_q.pop_front();
        chk("out_deriv", int'(out_deriv), ed);
        chk("out_delta", int'(out_delta), edl);
      end
      last_d     = int'(out_deriv);
      last_delta = int'(out_delta);
      got_out    = 1;
      n_out++;
      m_acc = sat(m_acc + int'(out_delta));
      m_cnt = (m_cnt + 1) % 65536;
    end
    stalled    = out_valid && !out_ready;
    hold_delta = int'(out_delta);
    hold_deriv = int'(out_deriv);
    @(posedge clk);
    #1;
    chk("acc_sum", int'(acc_sum), m_acc);
    chk("sample_cnt", int'(sample_cnt), m_cnt);
  endtask

  initial begin
    bit f;
    int idx, n0, e;
    int s_bp[4];
    int e_bp[4];

    vecs[0] = '{s: 128, e: 256,  d: 64, delta: 64};
    vecs[1] = '{s: 64,  e: -256, d: 48, delta: -48};
    vecs[2] = '{s: 0,   e: 500,  d: 0,  delta: 0};
    vecs[3] = '{s: 256, e: 1000, d: 0,  delta: 0};
    vecs[4] = '{s: 300, e: -700, d: 0,  delta: 0};
    vecs[5] = '{s: 154, e: 3,    d: 61, delta: RND_154};
    vecs[6] = '{s: 154, e: -3,   d: 61, delta: -1};

    rst_n = 0; in_valid = 0; in_sig = 0; in_err = 0; out_ready = 1; acc_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_delta", int'(out_delta), 0);
    chk("rst_out_deriv", int'(out_deriv), 0);
    chk("rst_acc_sum", int'(acc_sum), 0);
    chk("rst_sample_cnt", int'(sample_cnt), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);

    // Directed table, one item at a time through an empty pipe.
    foreach (vecs[i]) begin
      got_out = 0;
      in_valid = 1; in_sig = 16'(vecs[i].s); in_err = 16'(vecs[i].e);
      cycle(f);
      chk("tbl_accept", int'(f), 1);
      in_valid = 0;
      chk("tbl_latency_not_yet", int'(out_valid), 0);
      cycle(f);
      chk("tbl_latency_valid", int'(out_valid), 1);
      cycle(f);
      chk("tbl_got_out", int'(got_out), 1);
      chk("tbl_deriv", last_d, vecs[i].d);
      chk("tbl_delta", last_delta, vecs[i].delta);
      if (i == 0) begin
        chk("first_acc_sum", int'(acc_sum), 64);
        chk("first_sample_cnt", int'(sample_cnt), 1);
      end
    end

    // Backpressure: four items against a stalled output.
    s_bp = '{128, 64, 200, 154};
    e_bp = '{256, -256, 1000, -3};
    idx = 0;
    n0 = n_out;
    out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; in_sig = 16'(s_bp[idx]); in_err = 16'(e_bp[idx]);
      cycle(f);
      if (f) idx++;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready_low", int'(in_ready), 0);
    out_ready = 1;
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) begin
        in_valid = 1; in_sig = 16'(s_bp[idx]); in_err = 16'(e_bp[idx]);
      end else begin
        in_valid = 0;
      end
      cycle(f);
      if (f) idx++;
      if (idx == 4 && exp_d_q.size() == 0 && !out_valid) break;
    end
    in_valid = 0;
    chk("bp_all_accepted", idx, 4);
    chk("bp_outputs", n_out - n0, 4);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_sig    = 16'($urandom_range(0, 300));
      e         = int'($urandom_range(0, 65535)) - 32768;
      in_err    = 16'(e);
      acc_clr   = ($urandom_range(0, 31) == 0);
      cycle(f);
    end
    acc_clr = 0; in_valid = 0; out_ready = 1;
    repeat (4) cycle(f);
    chk("rand_drained", exp_d_q.size(), 0);

    // Saturation: delta 8191 per item drives the sum to the positive rail.
    acc_clr = 1;
    cycle(f);
    acc_clr = 0;
    in_valid = 1; in_sig = 16'(128); in_err = 16'(32767);
    repeat (1040) cycle(f);
    in_valid = 0;
    repeat (3) cycle(f);
    chk("sat_acc_max", int'(acc_sum), ACC_MAX);
    in_valid = 1; in_sig = 16'(64); in_err = 16'(-256);
    cycle(f);
    in_valid = 0;
    cycle(f);
    acc_clr = 1;
    cycle(f);
    acc_clr = 0;
    chk("clr_fire_acc", int'(acc_sum), -48);
    chk("clr_fire_cnt", int'(sample_cnt), 1);
    repeat (3) cycle(f);
    chk("drained", exp_d_q.size(), 0);

    // Reset with two items in flight.
    out_ready = 0;
    in_valid = 1; in_sig = 16'(100); in_err = 16'(50);
    idx = 0;
    repeat (2) begin
      cycle(f);
      if (f) idx++;
    end
    in_valid = 0;
    chk("inflight_accepted", idx, 2);
    #2;
    rst_n = 0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_acc_sum", int'(acc_sum), 0);
    chk("midrst_sample_cnt", int'(sample_cnt), 0);
    exp_d_q.delete();
    exp_delta_q.delete();
    m_acc = 0; m_cnt = 0; stalled = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      cycle(f);
      chk("post_rst_no_output", int'(out_valid), 0);
      chk("post_rst_in_ready", int'(in_ready), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sig_bwd_delta.md
Name: sig_bwd_delta

Overview:
- Backward-pass partner of the forward sigmoid lookup in the XOR trainer.
- Takes a stored sigmoid activation s and a back-propagated error e, both Q8.8. Computes the derivative d = s·(1−s) and the local gradient delta = e·d.
- 2-stage valid/ready pipeline. A gradient accumulator and sample counter feed the weight-update logic.

Parameters:
- DATA_W, 16, width of s, e and delta (Q8.8; 256 = 1.0)
- ACC_W, 24, width of the signed gradient accumulator
- CNT_W, 16, width of the accepted-sample counter

Ports:
- clk  in  1  clock; all state on posedge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  s/e pair offered
- in_ready  out  1  pipeline can accept this cycle
- in_sig  in  DATA_W  sigmoid activation, unsigned Q8.8, legal 0..256
- in_err  in  DATA_W  error term, signed Q8.8
- out_valid  out  1  delta available
- out_ready  in  1  downstream consumes delta
- out_delta  out  DATA_W  signed Q8.8 local gradient
- out_deriv  out  DATA_W  unsigned Q8.8 derivative paired with out_delta
- acc_clr  in  1  synchronous clear of accumulator and counter
- acc_sum  out  ACC_W  signed saturating sum of emitted deltas
- sample_cnt  out  CNT_W  number of deltas emitted since clear, wraps

Behaviour:
- Reset (async, rst_n=0): stage valids=0, out_valid=0, out_delta=0, out_deriv=0, acc_sum=0, sample_cnt=0.
- in_ready reflects reset state: in_ready=1 once rst_n is released.
- Handshakes:
  - Input fire = in_valid && in_ready.
  - Output fire = out_valid && out_ready.
  - in_ready = !s1_valid || s1_adv, where s1_adv = !out_valid || out_ready. No combinational path from in_valid to in_ready.
- Stage 1 (on input fire):
  - Clamp: sc = min(in_sig, 256).
  - d = (sc·(256−sc)) >> 8, truncated; range 0..64.
  - Register d, in_err, s1_valid=1.
- Stage 2 (on s1_adv && s1_valid):
  - p = signed(e)·d as 32-bit signed.
  - delta = p >>> 8; |delta| ≤ |e|/4, so no overflow.
  - Register out_delta, out_deriv=d; set out_valid=1.
- Latency: 2 cycles from input fire to out_valid when out_ready is held 1. Throughput: 1 per cycle.
- Backpressure: out_ready=0 holds out_* stable. A second item may fill stage 1, then in_ready drops. No item is lost or duplicated; output order equals input order.
- Emptying: out_valid clears after an output fire if stage 1 is not advancing a new item.
- Accumulator, on output fire:
  - acc_sum += sign-extended out_delta.
  - Saturate to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - sample_cnt += 1, wrapping from 2^CNT_W−1 to 0.
- acc_clr:
  - Alone: acc_sum=0, sample_cnt=0.
  - With a simultaneous output fire: acc_sum=out_delta, sample_cnt=1 (clear first, then add).
- Reset mid-operation: in-flight items are discarded; no output is produced for them after reset releases.

Optional Feature:
- Macro: SIG_BWD_ROUND_EN.
- Defined: delta = (p + 128) >>> 8, i.e. round half toward +inf. d stays truncated.
- Undefined: delta = p >>> 8 (floor).

Decomposition:
- Package sig_bwd_pkg holds:
  - Q8.8 constants: Q_FRAC=8, Q_ONE=256, Q_HALF=128.
  - DATA_W/ACC_W defaults.
  - Typedefs q88_t (signed 16) and uq88_t (unsigned 16).
  - Accumulator saturation bounds.
- One sub-module, sig_deriv_calc: combinational clamp plus s·(1−s) producing d. Reused by the future weight-update unit.

Test Plan:
- s=128, e=256, out_ready=1 -> after 2 cycles out_deriv=64, out_delta=64, acc_sum=64, sample_cnt=1.
- s=64, e=−256 -> out_deriv=48, out_delta=−48. Boundaries: s=0 -> d=0, delta=0; s=256 -> d=0; s=300 -> clamped, d=0.
- s=154, e=3 -> d=61. Without macro delta=0; with SIG_BWD_ROUND_EN delta=1. Same s with e=−3 -> delta=−1 in both builds.
- Stream 4 items with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepted. out_delta is stable while stalled. On release, all 4 emerge in order, no loss or duplicate.
- Pre-load acc_sum near 2^23−1 using s=128, e=32767 repeatedly -> acc_sum saturates at 8388607 and stays there. Assert acc_clr during an output fire -> acc_sum=that delta, sample_cnt=1.
- Deassert rst_n with 2 items in flight -> out_valid=0, acc_sum=0, sample_cnt=0 immediately. After release, no stale output appears; in_ready=1.
